l15_req_arbiter: RTL
====================

# l15_req_arbiter

Arbitrates the core's single OpenPiton L1.5 transducer request channel between the instruction-fetch unit and the load/store unit. It holds one transaction outstanding at a time and routes each L1.5 response back to the requester that issued it. It absorbs wake-up interrupts and gates all issue until the core is woken and the cache reports ready. It sits between the frontend/LSU and the `transducer_l15_*` / `l15_transducer_*` core ports.

## Interface
- `RQ_LOAD`, 5'b00000, rqtype driven for fetch-unit-independent loads (LSU supplies its own rqtype; this constant is used only for checking)
- `RQ_IMISS`, 5'b10000, rqtype driven for instruction-fetch requests
- `RET_LOAD`, 4'b0000, returntype completing an LSU load
- `RET_IFILL`, 4'b0001, returntype completing a fetch
- `RET_STACK`, 4'b0100, returntype completing an LSU store
- `RET_INT`, 4'b0111, returntype of a wake-up interrupt
- `IFETCH_SIZE`, 3'b111, size field driven for fetch requests
- `TIMEOUT`, 1024, maximum cycles in WAIT_RESP before an error is flagged

Ports:
- `clk` in 1: clock, rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `if_req_val` in 1: fetch request valid.
- `if_req_addr` in 32: fetch address.
- `if_req_rdy` out 1: fetch request accepted this cycle when high together with `if_req_val`.
- `if_resp_val` out 1: fetch response valid.
- `if_resp_data` out 128: {data_1, data_0}.
- `ls_req_val` in 1: LSU request valid.
- `ls_req_rqtype` in 5: LSU rqtype.
- `ls_req_size` in 3: LSU size.
- `ls_req_addr` in 32: LSU address.
- `ls_req_data` in 32: LSU store data.
- `ls_req_rdy` out 1: LSU request accepted this cycle when high together with `ls_req_val`.
- `ls_resp_val` out 1: LSU response valid.
- `ls_resp_data` out 64: data_0.
- `transducer_l15_rqtype` out 5, `transducer_l15_size` out 3, `transducer_l15_address` out 32, `transducer_l15_data` out 32, `transducer_l15_val` out 1: L1.5 request.
- `l15_transducer_ack` in 1: request accepted.
- `l15_transducer_header_ack` in 1: cache ready.
- `l15_transducer_val` in 1, `l15_transducer_data_0` in 64, `l15_transducer_data_1` in 64, `l15_transducer_returntype` in 4: L1.5 response.
- `transducer_l15_req_ack` out 1: response consumed.
- `wakeup` out 1: one-cycle pulse on interrupt.
- `err_unexpected` out 1: sticky; set by an unmatched response.
- `err_timeout` out 1: sticky; set when TIMEOUT expires.

## Operation
- Sticky flags `woken` (set by a RET_INT response) and `cache_rdy` (set by `header_ack`==1). `issue_en = woken & cache_rdy`.
- FSM states:
  - IDLE: if `issue_en` and at least one requester is valid, grant one, latch its fields and `owner`, go to REQ.
  - REQ: `transducer_l15_val`=1 with the latched fields. When `l15_transducer_ack`=1, go to WAIT_RESP.
  - WAIT_RESP: a response whose returntype matches `owner` (fetch: RET_IFILL; LSU: RET_LOAD/RET_STACK) drives the requester's resp_val, then the FSM goes to IDLE.
- Arbitration: round-robin on `last_grant`. When both requesters are valid, grant the one not granted last. A single valid requester is always granted. Reset value of `last_grant` = LSU, so fetch wins the first tie.
- Fetch request fields: rqtype RQ_IMISS, size IFETCH_SIZE, data 0.
- `transducer_l15_req_ack` = `l15_transducer_val`, combinational: every response is consumed in its cycle, in any state.
- RET_INT in any state: `wakeup` pulses, `woken` is set, the FSM is unaffected, and it never produces a resp_val.
- Non-interrupt response in IDLE/REQ, or with a mismatched returntype in WAIT_RESP: dropped, `err_unexpected` set, state unchanged.
- Timeout counter: cleared on entry to WAIT_RESP. When it reaches TIMEOUT, `err_timeout` is set and the FSM returns to IDLE (transaction abandoned).

## Timing
- Reset values: all outputs 0. State IDLE, `woken`=0, `cache_rdy`=0, counter 0.
- A reset mid-transaction abandons it. `transducer_l15_val`=0 from the edge at which `nrst` is sampled low.
- `if_req_rdy`/`ls_req_rdy` are combinational, high only in IDLE with `issue_en` and the grant. Acceptance occurs at the edge where val&rdy are both high.
- `transducer_l15_val` rises the cycle after acceptance. It holds, with stable fields, until the edge at which `ack` is sampled high, and is 0 the following cycle.
- `if_resp_val`/`ls_resp_val` and their data are combinational from the matching response cycle, and last one cycle.
- `wakeup` is registered: it pulses in the cycle after RET_INT is sampled.
- The next request can be accepted the cycle after the response. Minimum of 3 cycles per transaction, with no gaps beyond that.

## Test plan
- Requests issued before wake-up: `if_req_val`=1 from reset, no RET_INT -> `transducer_l15_val` stays 0.
  - Then RET_INT with `header_ack`=0 -> `wakeup` pulses, still no issue.
  - Then `header_ack`=1 -> `transducer_l15_val`=1 next cycle with rqtype 5'b10000.
- Fetch round-trip: `if_req_addr`=0x1000, ack after 2 cycles, response RET_IFILL with data_0=0x00A00A1300208133, data_1=0x00A0202300002A83 -> `if_resp_data` = {data_1, data_0} for one cycle, `ls_resp_val`=0.
- Contention: both requesters valid continuously over 4 transactions -> grants alternate fetch, LSU, fetch, LSU.
  - An LSU store (rqtype 5'b00001, addr 0, data 10) completes on RET_STACK.
- Misrouted response: fetch outstanding, response RET_LOAD -> `err_unexpected`=1, no resp_val, FSM stays in WAIT_RESP.
  - A following RET_IFILL completes the fetch normally.
- Interrupt during WAIT_RESP: RET_INT -> `wakeup` pulses, `transducer_l15_req_ack`=1, and the outstanding fetch later completes.
- Timeout and reset: no response for TIMEOUT cycles -> `err_timeout`=1 and the next request is accepted.
  - `nrst`=0 while in REQ -> `transducer_l15_val`=0 and all flags are cleared the next cycle.

Source files
------------

// File: rtl/l15_req_arbiter.sv
// l15_req_arbiter
// ----------------
// Shares the core's single L1.5 transducer request channel between the
// instruction-fetch unit and the load/store unit. One transaction is in
// flight at a time, and each L1.5 response is routed back to the requester
// that issued it. Issue is held off until a wake-up interrupt has been seen
// and the cache has reported ready through header_ack.
//
// Ports
//   clk, nrst                      clock (rising edge), synchronous active-low reset
//   if_req_*                       fetch request: val/addr in, rdy out
//   if_resp_val, if_resp_data      fetch response {data_1, data_0}
//   ls_req_*                       LSU request: val/rqtype/size/addr/data in, rdy out
//   ls_resp_val, ls_resp_data      LSU response (data_0)
//   transducer_l15_*               request to the L1.5 (val, rqtype, size, address, data)
//   l15_transducer_ack             L1.5 accepted the request
//   l15_transducer_header_ack      L1.5 ready to accept requests
//   l15_transducer_val/data/rtype  response from the L1.5
//   transducer_l15_req_ack         response consumed (same cycle)
//   wakeup                         one-cycle pulse after an interrupt response
//   err_unexpected, err_timeout    sticky error flags
module l15_req_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         nrst,
   // fetch unit
   input  logic         if_req_val,
   input  logic [31:0]  if_req_addr,
   output logic         if_req_rdy,
   output logic         if_resp_val,
   output logic [127:0] if_resp_data,
   // load/store unit
   input  logic         ls_req_val,
   input  logic [4:0]   ls_req_rqtype,
   input  logic [2:0]   ls_req_size,
   input  logic [31:0]  ls_req_addr,
   input  logic [31:0]  ls_req_data,
   output logic         ls_req_rdy,
   output logic         ls_resp_val,
   output logic [63:0]  ls_resp_data,
   // L1.5 request channel
   output logic [4:0]   transducer_l15_rqtype,
   output logic [2:0]   transducer_l15_size,
   output logic [31:0]  transducer_l15_address,
   output logic [31:0]  transducer_l15_data,
   output logic         transducer_l15_val,
   input  logic         l15_transducer_ack,
   input  logic         l15_transducer_header_ack,
   // L1.5 response channel
   input  logic         l15_transducer_val,
   input  logic [63:0]  l15_transducer_data_0,
   input  logic [63:0]  l15_transducer_data_1,
   input  logic [3:0]   l15_transducer_returntype,
   output logic         transducer_l15_req_ack,
   // status
   output logic         wakeup,
   output logic         err_unexpected,
   output logic         err_timeout
);

   localparam logic [4:0] RQ_IMISS    = 5'b10000;
   localparam logic [3:0] RET_LOAD    = 4'b0000;
   localparam logic [3:0] RET_IFILL   = 4'b0001;
   localparam logic [3:0] RET_STACK   = 4'b0100;
   localparam logic [3:0] RET_INT     = 4'b0111;
   localparam logic [2:0] IFETCH_SIZE = 3'b111;
   localparam int         CNT_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_RESP = 2'd2
   } state_t;

   state_t             state_q;
   logic               owner_if_q;       // 1: fetch owns the outstanding transaction
   logic               last_grant_if_q;  // 1: fetch was granted last (reset: LSU)
   logic               woken_q;
   logic               cache_rdy_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [4:0]         rqtype_q;
   logic [2:0]         size_q;
   logic [31:0]        addr_q;
   logic [31:0]        data_q;
   logic               val_q;
   logic               wakeup_q;
   logic               err_unexp_q;
   logic               err_to_q;

   logic issue_en;
   logic grant_if;
   logic grant_ls;
   logic rsp_int;
   logic rsp_if;
   logic rsp_ls;
   logic rsp_bad;

   assign issue_en = woken_q & cache_rdy_q;

   // Round-robin only matters on a tie; a lone requester always wins.
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (state_q == IDLE && issue_en) begin
         if (if_req_val && ls_req_val) begin
            grant_if = ~last_grant_if_q;
            grant_ls = last_grant_if_q;
         end else begin
            grant_if = if_req_val;
            grant_ls = ls_req_val;
         end
      end
   end

   // Response classification. Interrupts are recognised in every state and
   // never count as a completion; anything else that does not complete the
   // outstanding transaction is dropped and flagged.
   always_comb begin
      rsp_int = l15_transducer_val && (l15_transducer_returntype == RET_INT);
      rsp_if  = l15_transducer_val && (state_q == WAIT_RESP) && owner_if_q &&
                (l15_transducer_returntype == RET_IFILL);
      rsp_ls  = l15_transducer_val && (state_q == WAIT_RESP) && !owner_if_q &&
                ((l15_transducer_returntype == RET_LOAD) ||
                 (l15_transducer_returntype == RET_STACK));
      rsp_bad = l15_transducer_val && !rsp_int && !rsp_if && !rsp_ls;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q         <= IDLE;
         owner_if_q      <= 1'b0;
         last_grant_if_q <= 1'b0;
         woken_q         <= 1'b0;
         cache_rdy_q     <= 1'b0;
         cnt_q           <= '0;
         rqtype_q        <= '0;
         size_q          <= '0;
         addr_q          <= '0;
         data_q          <= '0;
         val_q           <= 1'b0;
         wakeup_q        <= 1'b0;
         err_unexp_q     <= 1'b0;
         err_to_q        <= 1'b0;
      end else begin
         wakeup_q <= rsp_int;
         if (rsp_int)                   woken_q     <= 1'b1;
         if (l15_transducer_header_ack) cache_rdy_q <= 1'b1;
         if (rsp_bad)                   err_unexp_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (grant_if || grant_ls) begin
                  state_q         <= REQ;
                  val_q           <= 1'b1;
                  owner_if_q      <= grant_if;
                  last_grant_if_q <= grant_if;
                  if (grant_if) begin
                     rqtype_q <= RQ_IMISS;
                     size_q   <= IFETCH_SIZE;
                     addr_q   <= if_req_addr;
                     data_q   <= '0;
                  end else begin
                     rqtype_q <= ls_req_rqtype;
                     size_q   <= ls_req_size;
                     addr_q   <= ls_req_addr;
                     data_q   <= ls_req_data;
                  end
               end
            end
            REQ: begin
               if (l15_transducer_ack) begin
                  val_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               // A completing response in the final cycle still wins over the timeout.
               if (rsp_if || rsp_ls) begin
                  state_q <= IDLE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  err_to_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_req_rdy             = grant_if;
   assign ls_req_rdy             = grant_ls;
   assign if_resp_val            = rsp_if;
   assign if_resp_data           = rsp_if ? {l15_transducer_data_1, l15_transducer_data_0} : '0;
   assign ls_resp_val            = rsp_ls;
   assign ls_resp_data           = rsp_ls ? l15_transducer_data_0 : '0;
   assign transducer_l15_rqtype  = rqtype_q;
   assign transducer_l15_size    = size_q;
   assign transducer_l15_address = addr_q;
   assign transducer_l15_data    = data_q;
   assign transducer_l15_val     = val_q;
   assign transducer_l15_req_ack = l15_transducer_val;
   assign wakeup                 = wakeup_q;
   assign err_unexpected         = err_unexp_q;
   assign err_timeout            = err_to_q;

endmodule
